// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: picks the highest-priority pending mailbox, hands it to the
// frame builder, then serializes the frame MSB-first with arbitration-loss and ACK retry.
module can_tx_scheduler #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 1,
  parameter int DATA_W    = 16,
  parameter int FRAME_W   = 53,
  parameter int ARB_BITS  = 3,
  parameter int ACK_POS   = 11,
  parameter int MAX_RETRY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ID_W-1:0]     id_flat,
  input  logic [N_REQ*DATA_W-1:0]   data_flat,
  output logic [$clog2(N_REQ)-1:0]  grant_idx,
  output logic [ID_W-1:0]           grant_id,
  output logic [DATA_W-1:0]         grant_data,
  output logic                      build_start,
  input  logic                      frame_valid,
  input  logic [FRAME_W-1:0]        frame_in,
  input  logic                      bit_tick,
  output logic                      can_tx,
  input  logic                      can_rx,
  output logic                      busy,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FRAME_W);
  localparam int RC_W  = $clog2(MAX_RETRY + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_TX   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  grant_data_q, grant_data_d;
  logic               build_start_q, build_start_d;
  logic               can_tx_q, can_tx_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               started_q, started_d;
  logic [RC_W-1:0]    retry_q, retry_d;

  logic               found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [ID_W-1:0]    win_id_s;
  logic               arb_lost_s;
  logic               ack_err_s;

  // Bus level for frame bit k; the ACK slot is always left recessive.
  function automatic logic frame_bit(input logic [FRAME_W-1:0] f, input logic [CNT_W-1:0] k);
    if (k == CNT_W'(ACK_POS)) begin
      return 1'b1;
    end else begin
      return f[k];
    end
  endfunction

  // Lowest identifier wins; the ascending scan with strict '<' keeps ties on the lowest index.
  always_comb begin
    found_s   = 1'b0;
    win_idx_s = {IDX_W{1'b0}};
    win_id_s  = {ID_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (!found_s || (id_flat[i*ID_W +: ID_W] < win_id_s))) begin
        found_s   = 1'b1;
        win_idx_s = IDX_W'(i);
        win_id_s  = id_flat[i*ID_W +: ID_W];
      end else begin
        found_s   = found_s;
      end
    end
  end

  assign arb_lost_s = started_q && (bit_cnt_q >= CNT_W'(FRAME_W - ARB_BITS)) && can_tx_q && !can_rx;
  assign ack_err_s  = started_q && (bit_cnt_q == CNT_W'(ACK_POS)) && can_rx;

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    grant_id_d    = grant_id_q;
    grant_data_d  = grant_data_q;
    build_start_d = 1'b0;
    done_d        = {N_REQ{1'b0}};
    err_d         = {N_REQ{1'b0}};
    can_tx_d      = can_tx_q;
    frame_d       = frame_q;
    bit_cnt_d     = bit_cnt_q;
    started_d     = started_q;
    retry_d       = retry_q;
    case (state_q)
      S_IDLE: begin
        can_tx_d = 1'b1;
        if (found_s) begin
          grant_idx_d   = win_idx_s;
          grant_id_d    = win_id_s;
          grant_data_d  = data_flat[win_idx_s*DATA_W +: DATA_W];
          build_start_d = 1'b1;
          state_d       = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (frame_valid) begin
          frame_d   = frame_in;
          bit_cnt_d = CNT_W'(FRAME_W - 1);
          started_d = 1'b0;
          state_d   = S_TX;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_TX: begin
        if (!bit_tick) begin
          state_d = S_TX;
        end else if (!started_q) begin
          started_d = 1'b1;
          can_tx_d  = frame_bit(frame_q, bit_cnt_q);
        end else if (arb_lost_s) begin
          can_tx_d = 1'b1;
          state_d  = S_IDLE;
        end else if (ack_err_s) begin
          can_tx_d = 1'b1;
          if (retry_q < RC_W'(MAX_RETRY)) begin
            retry_d       = retry_q + RC_W'(1);
            build_start_d = 1'b1;
            state_d       = S_LOAD;
          end else begin
            err_d[grant_idx_q] = 1'b1;
            retry_d            = {RC_W{1'b0}};
            state_d            = S_IDLE;
          end
        end else if (bit_cnt_q == {CNT_W{1'b0}}) begin
          can_tx_d            = 1'b1;
          done_d[grant_idx_q] = 1'b1;
          retry_d             = {RC_W{1'b0}};
          state_d             = S_FIN;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          can_tx_d  = frame_bit(frame_q, bit_cnt_q - CNT_W'(1));
        end
      end
      S_FIN: begin
        can_tx_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        can_tx_d = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_idx_q   <= {IDX_W{1'b0}};
      grant_id_q    <= {ID_W{1'b0}};
      grant_data_q  <= {DATA_W{1'b0}};
      build_start_q <= 1'b0;
      can_tx_q      <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= {N_REQ{1'b0}};
      err_q         <= {N_REQ{1'b0}};
      frame_q       <= {FRAME_W{1'b0}};
      bit_cnt_q     <= {CNT_W{1'b0}};
      started_q     <= 1'b0;
      retry_q       <= {RC_W{1'b0}};
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      grant_id_q    <= grant_id_d;
      grant_data_q  <= grant_data_d;
      build_start_q <= build_start_d;
      can_tx_q      <= can_tx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      frame_q       <= frame_d;
      bit_cnt_q     <= bit_cnt_d;
      started_q     <= started_d;
      retry_q       <= retry_d;
    end
  end

  assign grant_idx   = grant_idx_q;
  assign grant_id    = grant_id_q;
  assign grant_data  = grant_data_q;
  assign build_start = build_start_q;
  assign can_tx      = can_tx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Transmit scheduler for the CAN frame builder: arbitrates N local mailboxes by identifier priority and hands the winner's identifier/data to the builder.
- Waits for the assembled frame, then serializes it MSB-first onto can_tx, one bit per bit_tick.
- Monitors can_rx for bus-arbitration loss and a missing ACK; retries or reports error per mailbox.

Parameters:
N_REQ, 4, number of mailboxes
ID_W, 1, identifier width
DATA_W, 16, payload width per mailbox
FRAME_W, 53, builder frame width
ARB_BITS, 3, arbitration field length (SOF+ID+RTR), frame MSB downward
ACK_POS, 11, frame bit index of ACK slot
MAX_RETRY, 3, ACK-error retries before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  N_REQ  mailbox pending, level
id_flat  in  N_REQ*ID_W  mailbox i identifier at [i*ID_W +: ID_W]
data_flat  in  N_REQ*DATA_W  mailbox i payload at [i*DATA_W +: DATA_W]
grant_idx  out  $clog2(N_REQ)  selected mailbox
grant_id  out  ID_W  selected identifier to builder
grant_data  out  DATA_W  selected payload to builder
build_start  out  1  one-cycle pulse, builder latch
frame_valid  in  1  builder frame ready, level
frame_in  in  FRAME_W  assembled frame
bit_tick  in  1  one-cycle bit-time strobe
can_tx  out  1  bus drive, 1 = recessive
can_rx  in  1  sampled bus level
busy  out  1  state != IDLE
done  out  N_REQ  one-cycle success pulse per mailbox
err  out  N_REQ  one-cycle failure pulse per mailbox

Behaviour:
- Reset: state IDLE, can_tx=1, build_start=0, done=0, err=0, grant_* =0, retry count 0, bit counter 0. Reset mid-transmission aborts immediately; nothing pulses.
- States: IDLE, LOAD, WAIT_FRM, TX, FIN.
- IDLE: if any req, latch winner into grant_* -> LOAD next cycle.
- Winner: lowest grant_id wins. Ties go to the lowest index.
- LOAD: build_start=1 for exactly one cycle -> WAIT_FRM.
- WAIT_FRM: on frame_valid=1, copy frame_in to shift register, set bit counter=FRAME_W-1, then -> TX. Wait indefinitely otherwise.
- TX, first bit_tick: drive bit FRAME_W-1.
- TX, each later bit_tick: first evaluate the bit just completed (index k), then drive k-1.
- Arbitration loss: k in the arbitration field, can_tx=1 and can_rx=0. Set can_tx=1 that cycle and go to IDLE; retry count unchanged; re-arbitrate, and the same mailbox may win again.
- ACK slot: can_tx forced 1 at ACK_POS regardless of frame bit.
- ACK error: at the evaluation of ACK_POS, can_rx=1.
  - Retry count < MAX_RETRY: increment it, then -> LOAD with the same grant.
  - Otherwise: err[grant_idx]=1 for one cycle, clear the count, go to IDLE.
- Completion: tick after bit 0 completes -> FIN. can_tx=1, done[grant_idx]=1 for one cycle, retry count cleared -> IDLE.
- Between bit_ticks, can_tx holds. Outside TX, can_tx=1.
- Request handling: req changes during LOAD..FIN are ignored for the current grant, which finishes even if its req drops. New reqs are served after return to IDLE.
- Mailbox owner must deassert req on done/err. A still-high req re-arbitrates.
- Throughput: min 2 cycles IDLE->WAIT_FRM, plus FRAME_W+1 bit_ticks.

Test Plan:
- req=4'b0110, id1=1, id2=0, rx mirrors tx, ACK_POS rx=0 -> grant_idx=2. Serialized bits equal frame_in MSB-first over 53 ticks; done=4'b0100 for one cycle; can_tx=1 afterwards.
- Equal IDs on mailboxes 0 and 3 -> grant_idx=0 first. After done[0] with req0 dropped, mailbox 3 is sent.
- Force can_rx=0 while can_tx=1 at arbitration bit FRAME_W-2 -> can_tx=1, return to IDLE, no done/err. Retransmission succeeds when rx is released.
- Hold can_rx=1 at ACK slot every attempt -> 4 build_start pulses total, then err[grant_idx] for one cycle and no done. Same with ACK on 3rd attempt -> done, no err.
- Assert rst at bit 20 of TX -> next cycle can_tx=1, busy=0, no pulses. Fresh request transmits from the MSB.
- Delay frame_valid 10 cycles after build_start; drop req mid-TX -> no bits driven before frame_valid; done still pulses for the granted mailbox.
